// File: rtl/key_sched_pkg.sv
// Shared sizing constants and state encoding for the time-varying key scheduler.
package key_sched_pkg;

  localparam int KEY_W    = 18;
  localparam int NUM_KEYS = 6;
  localparam int WIN_LEN  = 6;
  localparam int PERIOD   = NUM_KEYS * WIN_LEN;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/key_table.sv
// Key word storage: one write port and one asynchronous read port, no reset.
module key_table #(
  parameter int KEY_W    = 18,
  parameter int NUM_KEYS = 6,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [KEY_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [KEY_W-1:0]  rdata
);

  logic [KEY_W-1:0] mem [NUM_KEYS];

  // Same negedge domain as the scheduler; contents survive rst and rekey.
  always_ff @(negedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/key_schedule_tx.sv
// Loads a table of key words, then replays one word per window to a locked FSM
// whose reset (lock_rst) is released on the same edge the schedule starts.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   LOAD  | accepting key words into the table; locked FSM held in reset
//   RUN   | cycling sched_cnt over the period; key_out = table[win_idx]
module key_schedule_tx #(
  parameter int KEY_W    = key_sched_pkg::KEY_W,
  parameter int NUM_KEYS = key_sched_pkg::NUM_KEYS,
  parameter int WIN_LEN  = key_sched_pkg::WIN_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_in_valid,
  input  logic [KEY_W-1:0] key_in_data,
  output logic             key_in_ready,
  input  logic             rekey,
  output logic [KEY_W-1:0] key_out,
  output logic             lock_rst,
  output logic [2:0]       win_idx,
  output logic             frame_start
);

  import key_sched_pkg::*;

  localparam logic [2:0] LAST_KEY  = 3'(NUM_KEYS - 1);
  localparam logic [6:0] LAST_CNT  = 7'(NUM_KEYS * WIN_LEN - 1);
  localparam logic [6:0] WIN_LEN_C = 7'(WIN_LEN);

  state_t           state;
  logic [2:0]       load_idx;
  logic [6:0]       sched_cnt;
  logic             wr_en;
  logic [2:0]       win_calc;
  logic [KEY_W-1:0] rd_key;

  assign wr_en    = (state == LOAD) && key_in_valid;
  assign win_calc = 3'(sched_cnt / WIN_LEN_C);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      load_idx  <= '0;
      sched_cnt <= '0;
      lock_rst  <= 1'b1;
    end else begin
      case (state)
        LOAD: begin
          if (key_in_valid) begin
            if (load_idx == LAST_KEY) begin
              load_idx  <= '0;
              sched_cnt <= '0;
              lock_rst  <= 1'b0;
              state     <= RUN;
            end else begin
              load_idx <= load_idx + 3'd1;
            end
          end
        end
        RUN: begin
          // rekey takes priority over the window/period wrap
          if (rekey) begin
            state     <= LOAD;
            lock_rst  <= 1'b1;
            sched_cnt <= '0;
            load_idx  <= '0;
          end else if (sched_cnt == LAST_CNT) begin
            sched_cnt <= '0;
          end else begin
            sched_cnt <= sched_cnt + 7'd1;
          end
        end
        default: begin
          state    <= LOAD;
          lock_rst <= 1'b1;
        end
      endcase
    end
  end

  key_table #(
    .KEY_W   (KEY_W),
    .NUM_KEYS(NUM_KEYS),
    .ADDR_W  (3)
  ) u_table (
    .clk  (clk),
    .we   (wr_en),
    .waddr(load_idx),
    .wdata(key_in_data),
    .raddr(win_calc),
    .rdata(rd_key)
  );

  // Table is unreset, so everything the locked FSM sees is masked outside RUN.
  assign key_in_ready = (state == LOAD);
  assign key_out      = (state == RUN) ? rd_key : '0;
  assign win_idx      = (state == RUN) ? win_calc : 3'd0;
  assign frame_start  = (state == RUN) && (sched_cnt == 7'd0);

endmodule
